// File: rtl/pyrm_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pyrm_decode_pkg
// Description : Shared types, RV64I base opcodes and decode helpers for the
//               pyrm decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pyrm_decode_pkg;

    // Immediate format selected by the opcode
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_t;

    // RV64I base opcodes (full 7-bit major opcode, low two bits are 2'b11)
    localparam logic [6:0] OP_LOAD     = 7'b000_0011;
    localparam logic [6:0] OP_MISC_MEM = 7'b000_1111;
    localparam logic [6:0] OP_OP_IMM   = 7'b001_0011;
    localparam logic [6:0] OP_AUIPC    = 7'b001_0111;
    localparam logic [6:0] OP_OP_IMM32 = 7'b001_1011;
    localparam logic [6:0] OP_STORE    = 7'b010_0011;
    localparam logic [6:0] OP_OP       = 7'b011_0011;
    localparam logic [6:0] OP_LUI      = 7'b011_0111;
    localparam logic [6:0] OP_OP_32    = 7'b011_1011;
    localparam logic [6:0] OP_BRANCH   = 7'b110_0011;
    localparam logic [6:0] OP_JALR     = 7'b110_0111;
    localparam logic [6:0] OP_JAL      = 7'b110_1111;
    localparam logic [6:0] OP_SYSTEM   = 7'b111_0011;

    // Decoded bundle presented to the execute stage
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [63:0] imm;
        logic        illegal;
    } dec_bundle_t;

    // True when the opcode is one of the thirteen RV64I base opcodes
    function automatic logic is_base_opcode(input logic [6:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_AUIPC, OP_OP_IMM32,
            OP_STORE, OP_OP, OP_LUI, OP_OP_32, OP_BRANCH, OP_JALR,
            OP_JAL, OP_SYSTEM: hit = 1'b1;
            default:           hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Immediate format for a legal opcode; R-type and unknown give IMM_NONE
    function automatic imm_type_t imm_type_of(input logic [6:0] op);
        imm_type_t t;
        t = IMM_NONE;
        case (op)
            OP_LOAD, OP_OP_IMM, OP_OP_IMM32,
            OP_JALR, OP_SYSTEM, OP_MISC_MEM: t = IMM_I;
            OP_STORE:                        t = IMM_S;
            OP_BRANCH:                       t = IMM_B;
            OP_LUI, OP_AUIPC:                t = IMM_U;
            OP_JAL:                          t = IMM_J;
            default:                         t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pyrm_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : pyrm_imm_gen
// Description : Combinational immediate generator and illegal-opcode detector
//               for a single 32-bit RV64I instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module pyrm_imm_gen
    import pyrm_decode_pkg::*;
(
    input  logic [31:0] inst_i,
    output imm_type_t   imm_type_o,
    output logic [63:0] imm_o,
    output logic        illegal_o
);

    logic w_illegal;

    // Classify the instruction; an illegal encoding never yields an immediate
    always_comb begin
        w_illegal  = !is_base_opcode(inst_i[6:0]) || (inst_i[1:0] != 2'b11);
        imm_type_o = w_illegal ? IMM_NONE : imm_type_of(inst_i[6:0]);
    end

    // Assemble and sign-extend the immediate for the selected format
    always_comb begin
        imm_o = 64'h0;
        case (imm_type_o)
            IMM_I: imm_o = {{52{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm_o = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm_o = {{51{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U: imm_o = {{32{inst_i[31]}}, inst_i[31:12], 12'h000};
            IMM_J: imm_o = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = 64'h0;
        endcase
    end

    assign illegal_o = w_illegal;

endmodule
`default_nettype wire

// File: rtl/pyrm_decode_block.sv
`default_nettype none
// ============================================================================
// Module      : pyrm_decode_block
// Description : Decode stage. Buffers paired pc/inst beats from fetch in a
//               small elastic queue and presents the decoded head entry to
//               execute with valid/retry handshaking and flush support.
// Revision    : 1.0 - initial release
// ============================================================================
module pyrm_decode_block
    import pyrm_decode_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_pyri,
    input  logic [63:0] pc_pyri,
    input  logic        pc_valid_pyri,
    output logic        pc_retry_pyro,
    input  logic [31:0] inst_pyri,
    input  logic        inst_valid_pyri,
    output logic        inst_retry_pyro,
    input  logic        flush_pyri,
    output logic        dec_valid_pyro,
    input  logic        dec_retry_pyri,
    output logic [63:0] dec_pc_pyro,
    output logic [31:0] dec_inst_pyro,
    output logic [6:0]  dec_op_pyro,
    output logic [4:0]  dec_rd_pyro,
    output logic [4:0]  dec_rs1_pyro,
    output logic [4:0]  dec_rs2_pyro,
    output logic [2:0]  dec_funct3_pyro,
    output logic [6:0]  dec_funct7_pyro,
    output logic [63:0] dec_imm_pyro,
    output logic        dec_illegal_pyro
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Queue storage and bookkeeping
    logic [63:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             w_full;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic [63:0]      w_head_pc;
    logic [31:0]      w_head_inst;
    imm_type_t        w_imm_type;
    logic [63:0]      w_imm;
    logic             w_illegal;
    dec_bundle_t      w_bundle;

    // Pointer increment that wraps at the queue depth
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Retry comes only from registered occupancy, so fetch never sees a
    // combinational path from its own valid back to its retry
    assign w_full          = (count_q == CNT_W'(DEPTH));
    assign w_valid         = (count_q != '0);
    assign pc_retry_pyro   = w_full;
    assign inst_retry_pyro = w_full;

    assign w_push = pc_valid_pyri & inst_valid_pyri & ~w_full;
    assign w_pop  = w_valid & ~dec_retry_pyri;

    // Next-state for pointers and occupancy; flush wins over push and pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_pyri) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (w_pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Bookkeeping registers, cleared immediately when reset asserts
    always_ff @(posedge clk or negedge reset_pyri) begin
        if (!reset_pyri) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; never read while empty, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_mem_q[tail_q]   <= pc_pyri;
            inst_mem_q[tail_q] <= inst_pyri;
        end
    end

    assign w_head_pc   = pc_mem_q[head_q];
    assign w_head_inst = inst_mem_q[head_q];

    pyrm_imm_gen u_imm_gen (
        .inst_i     (w_head_inst),
        .imm_type_o (w_imm_type),
        .imm_o      (w_imm),
        .illegal_o  (w_illegal)
    );

    // Build the output bundle; an empty queue presents a quiet bundle
    always_comb begin
        w_bundle    = '0;
        w_bundle.pc = RESET_PC;
        if (w_valid) begin
            w_bundle.pc      = w_head_pc;
            w_bundle.inst    = w_head_inst;
            w_bundle.op      = w_head_inst[6:0];
            w_bundle.rd      = w_head_inst[11:7];
            w_bundle.rs1     = w_head_inst[19:15];
            w_bundle.rs2     = w_head_inst[24:20];
            w_bundle.funct3  = w_head_inst[14:12];
            w_bundle.funct7  = w_head_inst[31:25];
            w_bundle.imm     = (w_imm_type == IMM_NONE) ? 64'h0 : w_imm;
            w_bundle.illegal = w_illegal;
        end
    end

    assign dec_valid_pyro   = w_valid;
    assign dec_pc_pyro      = w_bundle.pc;
    assign dec_inst_pyro    = w_bundle.inst;
    assign dec_op_pyro      = w_bundle.op;
    assign dec_rd_pyro      = w_bundle.rd;
    assign dec_rs1_pyro     = w_bundle.rs1;
    assign dec_rs2_pyro     = w_bundle.rs2;
    assign dec_funct3_pyro  = w_bundle.funct3;
    assign dec_funct7_pyro  = w_bundle.funct7;
    assign dec_imm_pyro     = w_bundle.imm;
    assign dec_illegal_pyro = w_bundle.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pyrm_decode_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_pyrm_decode_block
// Description : Self-checking bench for pyrm_decode_block against a queue
//               based reference model, with directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pyrm_decode_block;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset_pyri;
    logic [63:0] pc_pyri;
    logic        pc_valid_pyri;
    logic        pc_retry_pyro;
    logic [31:0] inst_pyri;
    logic        inst_valid_pyri;
    logic        inst_retry_pyro;
    logic        flush_pyri;
    logic        dec_valid_pyro;
    logic        dec_retry_pyri;
    logic [63:0] dec_pc_pyro;
    logic [31:0] dec_inst_pyro;
    logic [6:0]  dec_op_pyro;
    logic [4:0]  dec_rd_pyro;
    logic [4:0]  dec_rs1_pyro;
    logic [4:0]  dec_rs2_pyro;
    logic [2:0]  dec_funct3_pyro;
    logic [6:0]  dec_funct7_pyro;
    logic [63:0] dec_imm_pyro;
    logic        dec_illegal_pyro;

    int n_chk  = 0;
    int n_fail = 0;

    pyrm_decode_block #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset_pyri       (reset_pyri),
        .pc_pyri          (pc_pyri),
        .pc_valid_pyri    (pc_valid_pyri),
        .pc_retry_pyro    (pc_retry_pyro),
        .inst_pyri        (inst_pyri),
        .inst_valid_pyri  (inst_valid_pyri),
        .inst_retry_pyro  (inst_retry_pyro),
        .flush_pyri       (flush_pyri),
        .dec_valid_pyro   (dec_valid_pyro),
        .dec_retry_pyri   (dec_retry_pyri),
        .dec_pc_pyro      (dec_pc_pyro),
        .dec_inst_pyro    (dec_inst_pyro),
        .dec_op_pyro      (dec_op_pyro),
        .dec_rd_pyro      (dec_rd_pyro),
        .dec_rs1_pyro     (dec_rs1_pyro),
        .dec_rs2_pyro     (dec_rs2_pyro),
        .dec_funct3_pyro  (dec_funct3_pyro),
        .dec_funct7_pyro  (dec_funct7_pyro),
        .dec_imm_pyro     (dec_imm_pyro),
        .dec_illegal_pyro (dec_illegal_pyro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [193:0] act, input logic [193:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] base_ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                  7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    function automatic logic ref_illegal(input logic [31:0] i);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 13; k++) if (base_ops[k] == i[6:0]) found = 1'b1;
        return !found;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        logic signed [63:0] v;
        v = 64'sd0;
        case (i[6:0])
            7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73: v = 64'(signed'(i[31:20]));
            7'h23: v = 64'(signed'({i[31:25], i[11:7]}));
            7'h63: v = 64'(signed'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            7'h37, 7'h17: v = 64'(signed'({i[31:12], 12'h000}));
            7'h6F: v = 64'(signed'({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: v = 64'sd0;
        endcase
        return v;
    endfunction

    logic [95:0] mq [$];   // {pc, inst} entries, front is the head

    // Model state advance: occupancy-based retry, pop/push, flush, reset
    always @(posedge clk or negedge reset_pyri) begin
        if (!reset_pyri) begin
            mq.delete();
        end else begin
            logic m_push, m_pop;
            m_push = pc_valid_pyri && inst_valid_pyri && (mq.size() < 2);
            m_pop  = (mq.size() != 0) && !dec_retry_pyri;
            if (flush_pyri) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back({pc_pyri, inst_pyri});
            end
        end
    end

    // Per-cycle comparison of every output against the model
    logic [193:0] exp_b, act_b;
    always @(negedge clk) begin
        if (mq.size() == 0) begin
            exp_b = {1'b0, RESET_PC, 32'h0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 64'h0, 1'b0};
        end else begin
            logic [63:0] p;
            logic [31:0] i;
            {p, i} = mq[0];
            exp_b = {1'b1, p, i, i[6:0], i[11:7], i[19:15], i[24:20], i[14:12],
                     i[31:25], ref_illegal(i) ? 64'h0 : ref_imm(i), ref_illegal(i)};
        end
        act_b = {dec_valid_pyro, dec_pc_pyro, dec_inst_pyro, dec_op_pyro, dec_rd_pyro,
                 dec_rs1_pyro, dec_rs2_pyro, dec_funct3_pyro, dec_funct7_pyro,
                 dec_imm_pyro, dec_illegal_pyro};
        chk("bundle", act_b, exp_b);
        chk("retry", {pc_retry_pyro, inst_retry_pyro}, {2{mq.size() == 2}});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic pv, input logic iv, input logic [63:0] p,
                       input logic [31:0] i, input logic dr, input logic fl);
        pc_valid_pyri   = pv;
        inst_valid_pyri = iv;
        pc_pyri         = p;
        inst_pyri       = i;
        dec_retry_pyri  = dr;
        flush_pyri      = fl;
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input logic dr);
        cyc(1'b0, 1'b0, 64'h0, 32'h0, dr, 1'b0);
    endtask

    initial begin
        reset_pyri      = 1'b0;
        pc_valid_pyri   = 1'b0;
        inst_valid_pyri = 1'b0;
        pc_pyri         = 64'h0;
        inst_pyri       = 32'h0;
        dec_retry_pyri  = 1'b0;
        flush_pyri      = 1'b0;
        @(negedge clk);
        #2;

        // Reset held low for two cycles while fetch offers data
        cyc(1'b1, 1'b1, 64'h1234, 32'h00000013, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 64'h1234, 32'h00000013, 1'b0, 1'b0);
        chk("rst_valid", dec_valid_pyro, 0);
        chk("rst_retry", pc_retry_pyro, 0);
        chk("rst_pc", dec_pc_pyro, 64'h0);
        chk("rst_imm", dec_imm_pyro, 64'h0);
        reset_pyri = 1'b1;
        idle(1'b0);

        // Model pins
        chk("pin_imm_addi", ref_imm(32'hFFF10093), 64'hFFFFFFFFFFFFFFFF);
        chk("pin_imm_beq", ref_imm(32'hFE000EE3), 64'hFFFFFFFFFFFFFFFC);
        chk("pin_imm_jal", ref_imm(32'h008000EF), 64'h8);
        chk("pin_ill_zero", ref_illegal(32'h0), 1);

        // addi x1,x2,-1 seen one cycle after acceptance
        cyc(1'b1, 1'b1, 64'h80000000, 32'hFFF10093, 1'b0, 1'b0);
        chk("addi_valid", dec_valid_pyro, 1);
        chk("addi_fields", {dec_rd_pyro, dec_rs1_pyro, dec_funct3_pyro}, {5'd1, 5'd2, 3'd0});
        chk("addi_imm", dec_imm_pyro, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_illegal", dec_illegal_pyro, 0);
        idle(1'b0);

        // Back-pressure: two accepted, third held, then drain in order
        cyc(1'b1, 1'b1, 64'hA00, 32'h00100113, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 64'hB00, 32'h00200193, 1'b1, 1'b0);
        chk("bp_retry_full", pc_retry_pyro, 1);
        cyc(1'b1, 1'b1, 64'hC00, 32'h00300213, 1'b1, 1'b0);
        chk("bp_head_a", dec_pc_pyro, 64'hA00);
        cyc(1'b1, 1'b1, 64'hC00, 32'h00300213, 1'b0, 1'b0);
        chk("bp_head_b", dec_pc_pyro, 64'hB00);
        cyc(1'b1, 1'b1, 64'hC00, 32'h00300213, 1'b0, 1'b0);
        chk("bp_head_c", dec_pc_pyro, 64'hC00);
        idle(1'b0);
        chk("bp_empty", dec_valid_pyro, 0);

        // Branch and jump immediates
        cyc(1'b1, 1'b1, 64'h100, 32'hFE000EE3, 1'b0, 1'b0);
        chk("beq_imm", dec_imm_pyro, 64'hFFFFFFFFFFFFFFFC);
        cyc(1'b1, 1'b1, 64'h104, 32'h008000EF, 1'b0, 1'b0);
        chk("jal_imm", dec_imm_pyro, 64'h8);
        chk("jal_rd", dec_rd_pyro, 5'd1);
        idle(1'b0);

        // All-zero word is illegal; a lone pc_valid transfers nothing
        cyc(1'b1, 1'b1, 64'h200, 32'h00000000, 1'b1, 1'b0);
        chk("zero_illegal", {dec_valid_pyro, dec_illegal_pyro, dec_imm_pyro}, {2'b11, 64'h0});
        cyc(1'b1, 1'b0, 64'h204, 32'h00000013, 1'b1, 1'b0);
        chk("lone_pc_retry", pc_retry_pyro, 0);
        chk("lone_pc_head", dec_pc_pyro, 64'h200);
        idle(1'b0);

        // Flush at full occupancy
        cyc(1'b1, 1'b1, 64'h300, 32'h00000013, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 64'h304, 32'h00000013, 1'b1, 1'b0);
        chk("fl_full", pc_retry_pyro, 1);
        cyc(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        chk("fl_valid", dec_valid_pyro, 0);
        chk("fl_retry", pc_retry_pyro, 0);

        // Push during flush at count 1 is dropped
        cyc(1'b1, 1'b1, 64'h400, 32'h00000013, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 64'h404, 32'h00000013, 1'b0, 1'b1);
        chk("fl_push_drop", dec_valid_pyro, 0);
        idle(1'b0);
        chk("fl_push_drop2", dec_valid_pyro, 0);

        // Randomised traffic with occasional flush and mid-stream reset
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ri;
            logic        pv, iv;
            ri = $urandom;
            if ($urandom_range(0, 9) < 8) ri[6:0] = base_ops[$urandom_range(0, 12)];
            pv = ($urandom_range(0, 9) < 7);
            iv = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) reset_pyri = 1'b0;
            cyc(pv, iv, {$urandom, $urandom}, ri, ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 19) == 0));
            reset_pyri = 1'b1;
        end
        idle(1'b0);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
